// File: rtl/vga_sprite_mixer.sv
// Pipelined VGA compositor: scaled background plus NUM_SPR keyed sprites, sprite 0 on top.
// Drives sync-read ROM addresses and keeps a per-frame sprite-0 collision flag.
module vga_sprite_mixer #(
    parameter int unsigned NUM_SPR  = 4,
    parameter int unsigned SPR_W    = 30,
    parameter int unsigned SPR_H    = 37,
    parameter int unsigned SPR_AW   = 11,
    parameter int unsigned BG_SHIFT = 1,
    parameter int unsigned BG_W     = 320,
    parameter int unsigned BG_AW    = 17,
    parameter int unsigned ROM_LAT  = 1,
    parameter logic [7:0]  KEY      = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                hc,
    input  logic [9:0]                vc,
    input  logic                      video_on,
    input  logic [10*NUM_SPR-1:0]     spr_x,
    input  logic [10*NUM_SPR-1:0]     spr_y,
    input  logic [NUM_SPR-1:0]        spr_en,
    output logic [BG_AW-1:0]          bg_addr,
    input  logic [7:0]                bg_data,
    output logic [SPR_AW*NUM_SPR-1:0] spr_addr,
    input  logic [8*NUM_SPR-1:0]      spr_data,
    output logic [3:0]                vgaRed,
    output logic [3:0]                vgaGreen,
    output logic [3:0]                vgaBlue,
    output logic                      coll
);

    localparam int unsigned DLY = ROM_LAT + 1;

    localparam logic signed [11:0] HALF_W = 12'(SPR_W / 2);
    localparam logic signed [11:0] HALF_H = 12'(SPR_H / 2);
    localparam logic signed [11:0] SW     = 12'(SPR_W);
    localparam logic signed [11:0] SH     = 12'(SPR_H);

    logic [NUM_SPR-1:0]        hit_d;
    logic [SPR_AW*NUM_SPR-1:0] spr_addr_d;
    logic [BG_AW-1:0]          bg_addr_d;
    logic                      org_d;

    // 12-bit signed offsets so hc-left cannot wrap for boxes hanging off either edge.
    for (genvar i = 0; i < NUM_SPR; i++) begin : g_box
        logic signed [11:0] left, top, dx, dy;
        logic [SPR_AW-1:0]  lin;

        assign left = $signed({2'b00, spr_x[10*i +: 10]}) - HALF_W;
        assign top  = $signed({2'b00, spr_y[10*i +: 10]}) - HALF_H;
        assign dx   = $signed({2'b00, hc}) - left;
        assign dy   = $signed({2'b00, vc}) - top;
        assign hit_d[i] = spr_en[i] && (dx >= 0) && (dx < SW) && (dy >= 0) && (dy < SH);
        assign lin  = SPR_AW'(dx) + SPR_AW'(dy) * SPR_AW'(SPR_W);
        assign spr_addr_d[SPR_AW*i +: SPR_AW] = hit_d[i] ? lin : '0;
    end

    assign bg_addr_d = BG_AW'(hc >> BG_SHIFT) + BG_AW'(BG_W) * BG_AW'(vc >> BG_SHIFT);
    assign org_d     = (hc == 10'd0) && (vc == 10'd0);

    // Side-band flags ride alongside the ROM access so they line up with the returned data.
    logic [NUM_SPR-1:0] hit_pipe [DLY];
    logic [DLY-1:0]     von_pipe;
    logic [DLY-1:0]     org_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            bg_addr  <= '0;
            spr_addr <= '0;
            von_pipe <= '0;
            org_pipe <= '0;
            for (int i = 0; i < int'(DLY); i++) begin
                hit_pipe[i] <= '0;
            end
        end else begin
            bg_addr     <= bg_addr_d;
            spr_addr    <= spr_addr_d;
            von_pipe    <= {von_pipe[DLY-2:0], video_on};
            org_pipe    <= {org_pipe[DLY-2:0], org_d};
            hit_pipe[0] <= hit_d;
            for (int i = 1; i < int'(DLY); i++) begin
                hit_pipe[i] <= hit_pipe[i-1];
            end
        end
    end

    logic [NUM_SPR-1:0] opaque;
    logic [7:0]         pix;
    logic               others;
    logic               set_coll;
    logic [11:0]        rgb_d;

    always_comb begin
        opaque = '0;
        pix    = bg_data;
        others = 1'b0;
        // Walk from the lowest priority up so the lowest opaque index ends up in pix.
        for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
            opaque[i] = hit_pipe[DLY-1][i] && (spr_data[8*i +: 8] != KEY);
            if (opaque[i]) begin
                pix = spr_data[8*i +: 8];
            end
        end
        for (int i = 1; i < int'(NUM_SPR); i++) begin
            others = others | opaque[i];
        end
        set_coll = opaque[0] && others;
        rgb_d    = von_pipe[DLY-1] ?
                   {pix[7:5], pix[7], pix[4:2], pix[4], pix[1:0], pix[1:0]} : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vgaRed   <= '0;
            vgaGreen <= '0;
            vgaBlue  <= '0;
            coll     <= 1'b0;
        end else begin
            {vgaRed, vgaGreen, vgaBlue} <= rgb_d;
            // A collision on the frame's first pixel must survive the frame clear.
            if (set_coll) begin
                coll <= 1'b1;
            end else if (org_pipe[DLY-1]) begin
                coll <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sprite_mixer.sv
// Scoreboard bench for vga_sprite_mixer: behavioural pixel model with ROM emulation,
// directed corner cases followed by randomized pixels, sprites and resets.
module tb_vga_sprite_mixer;

    localparam int NUM_SPR  = 4;
    localparam int SPR_W    = 30;
    localparam int SPR_H    = 37;
    localparam int SPR_AW   = 11;
    localparam int BG_SHIFT = 1;
    localparam int BG_W     = 320;
    localparam int BG_AW    = 17;
    localparam logic [7:0] KEY = 8'h00;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [9:0]                hc = '0;
    logic [9:0]                vc = '0;
    logic                      video_on = 1'b0;
    logic [10*NUM_SPR-1:0]     spr_x = '0;
    logic [10*NUM_SPR-1:0]     spr_y = '0;
    logic [NUM_SPR-1:0]        spr_en = '0;
    logic [BG_AW-1:0]          bg_addr;
    logic [7:0]                bg_data;
    logic [SPR_AW*NUM_SPR-1:0] spr_addr;
    logic [8*NUM_SPR-1:0]      spr_data;
    logic [3:0]                vgaRed, vgaGreen, vgaBlue;
    logic                      coll;

    vga_sprite_mixer #(
        .NUM_SPR (NUM_SPR),
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .SPR_AW  (SPR_AW),
        .BG_SHIFT(BG_SHIFT),
        .BG_W    (BG_W),
        .BG_AW   (BG_AW),
        .ROM_LAT (1),
        .KEY     (KEY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hc      (hc),
        .vc      (vc),
        .video_on(video_on),
        .spr_x   (spr_x),
        .spr_y   (spr_y),
        .spr_en  (spr_en),
        .bg_addr (bg_addr),
        .bg_data (bg_data),
        .spr_addr(spr_addr),
        .spr_data(spr_data),
        .vgaRed  (vgaRed),
        .vgaGreen(vgaGreen),
        .vgaBlue (vgaBlue),
        .coll    (coll)
    );

    always #5 clk = ~clk;

    // ROM contents and a one-cycle synchronous read port per ROM.
    logic [7:0] bg_mem  [2**BG_AW];
    logic [7:0] spr_mem [NUM_SPR][2**SPR_AW];

    always @(posedge clk) begin
        bg_data <= bg_mem[bg_addr];
        for (int i = 0; i < NUM_SPR; i++) begin
            spr_data[8*i +: 8] <= spr_mem[i][spr_addr[SPR_AW*i +: SPR_AW]];
        end
    end

    typedef struct packed {
        logic [11:0] rgb;
        logic        coll;
    } pix_exp_t;

    typedef struct packed {
        logic [BG_AW-1:0]          bg;
        logic [SPR_AW*NUM_SPR-1:0] spr;
    } addr_exp_t;

    pix_exp_t  pix_q  [$];
    addr_exp_t addr_q [$];

    int sx [NUM_SPR];
    int sy [NUM_SPR];
    bit sen[NUM_SPR];
    bit m_coll;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [11:0] expand(input logic [7:0] p);
        logic [3:0] r, g, b;
        r = {p[7:5], p[7]};
        g = {p[4:2], p[4]};
        b = {p[1:0], p[1:0]};
        return {r, g, b};
    endfunction

    // One pixel clock: apply inputs and push what the DUT must produce for them.
    task automatic cycle(input int h, input int v, input bit von, input bit r);
        pix_exp_t  pe;
        addr_exp_t ae;
        logic [7:0] p;
        bit won;
        bit op [NUM_SPR];
        int n_other;
        @(negedge clk);
        hc = 10'(h);
        vc = 10'(v);
        video_on = von;
        rst = r;
        for (int i = 0; i < NUM_SPR; i++) begin
            spr_x[10*i +: 10] = 10'(sx[i]);
            spr_y[10*i +: 10] = 10'(sy[i]);
            spr_en[i] = sen[i];
        end
        if (r) begin
            // Reset also blanks whatever is still inside the pipeline.
            for (int i = 0; i < pix_q.size(); i++) pix_q[i] = '0;
            m_coll = 1'b0;
            pix_q.push_back('0);
            addr_q.push_back('0);
        end else begin
            ae.bg = BG_AW'(((h >> BG_SHIFT) + BG_W * (v >> BG_SHIFT)) % (2**BG_AW));
            ae.spr = '0;
            p = bg_mem[ae.bg];
            won = 1'b0;
            n_other = 0;
            for (int i = 0; i < NUM_SPR; i++) begin
                int dx, dy, a;
                bit hit;
                dx = h - (sx[i] - SPR_W / 2);
                dy = v - (sy[i] - SPR_H / 2);
                hit = sen[i] && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H;
                a = hit ? dx + dy * SPR_W : 0;
                ae.spr[SPR_AW*i +: SPR_AW] = SPR_AW'(a);
                op[i] = hit && (spr_mem[i][a] != KEY);
                if (op[i] && !won) begin
                    p = spr_mem[i][a];
                    won = 1'b1;
                end
                if (i > 0 && op[i]) n_other++;
            end
            if (op[0] && n_other > 0) m_coll = 1'b1;
            else if (h == 0 && v == 0) m_coll = 1'b0;
            pe.rgb = von ? expand(p) : 12'h000;
            pe.coll = m_coll;
            pix_q.push_back(pe);
            addr_q.push_back(ae);
        end
    endtask

    // Monitor: addresses appear one edge after stimulus, pixels three edges after.
    initial begin
        pix_exp_t  pe;
        addr_exp_t ae;
        forever begin
            @(posedge clk);
            #1;
            if (addr_q.size() >= 1) begin
                ae = addr_q.pop_front();
                chk("bg_addr", 64'(bg_addr), 64'(ae.bg));
                chk("spr_addr", 64'(spr_addr), 64'(ae.spr));
            end
            if (pix_q.size() >= 3) begin
                pe = pix_q.pop_front();
                chk("rgb", 64'({vgaRed, vgaGreen, vgaBlue}), 64'(pe.rgb));
                chk("coll", 64'(coll), 64'(pe.coll));
            end
        end
    end

    initial begin
        m_coll = 1'b0;
        for (int i = 0; i < NUM_SPR; i++) begin
            sx[i] = 0;
            sy[i] = 0;
            sen[i] = 1'b0;
        end
        for (int a = 0; a < 2**BG_AW; a++) bg_mem[a] = 8'($urandom);
        for (int i = 0; i < NUM_SPR; i++) begin
            for (int a = 0; a < 2**SPR_AW; a++) begin
                spr_mem[i][a] = ($urandom_range(0, 3) == 0) ? KEY : 8'($urandom_range(1, 255));
            end
        end
        bg_mem[645]     = 8'hE0;   // hc=10, vc=4: 5 + 320*2
        spr_mem[0][0]   = 8'hFF;
        spr_mem[0][555] = 8'h1C;   // box centre: 15 + 18*30
        spr_mem[1][555] = 8'hE3;
        spr_mem[0][556] = KEY;
        spr_mem[1][556] = 8'h03;
        spr_mem[0][370] = 8'h55;   // hc=0, vc=0 with left=-10, top=-12
        spr_mem[1][370] = 8'hAA;

        // Power-on reset, a short line, then a mid-line reset.
        for (int i = 0; i < 3; i++) cycle(i, 10, 1'b1, 1'b1);
        for (int i = 20; i < 25; i++) cycle(i, 10, 1'b1, 1'b0);
        for (int i = 25; i < 28; i++) cycle(i, 10, 1'b1, 1'b1);
        for (int i = 28; i < 34; i++) cycle(i, 10, 1'b1, 1'b0);

        cycle(10, 4, 1'b1, 1'b0);   // background only

        sen[0] = 1'b1; sx[0] = 100; sy[0] = 100;
        cycle(85, 82, 1'b1, 1'b0);  // top-left corner of the box
        cycle(84, 82, 1'b1, 1'b0);  // one column left: miss
        cycle(114, 118, 1'b1, 1'b0);
        cycle(115, 82, 1'b1, 1'b0);

        sen[1] = 1'b1; sx[0] = 200; sy[0] = 200; sx[1] = 200; sy[1] = 200;
        cycle(200, 200, 1'b1, 1'b0);  // both opaque: sprite 0 wins, collision
        cycle(201, 200, 1'b1, 1'b0);  // sprite 0 keyed: sprite 1 shows

        sx[0] = 400; sy[0] = 300;
        cycle(0, 0, 1'b1, 1'b0);      // frame start with no overlap clears
        sx[0] = 200; sy[0] = 200;
        cycle(200, 200, 1'b1, 1'b0);
        sx[0] = 5; sy[0] = 6; sx[1] = 5; sy[1] = 6;
        cycle(0, 0, 1'b1, 1'b0);      // overlap on the clearing pixel keeps coll
        cycle(1020, 0, 1'b0, 1'b0);   // no wrap-around hit from the left overhang
        sx[0] = 1020;
        cycle(3, 0, 1'b1, 1'b0);      // nor from the right overhang

        for (int n = 0; n < 3000; n++) begin
            int h, v;
            if (n % 64 == 0) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    sx[i] = $urandom_range(0, 160);
                    sy[i] = $urandom_range(0, 160);
                    sen[i] = ($urandom_range(0, 4) != 0);
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                h = 0;
                v = 0;
            end else begin
                h = $urandom_range(0, 180);
                v = $urandom_range(0, 180);
            end
            cycle(h, v, ($urandom_range(0, 7) != 0), ($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 4; i++) cycle(700, 500, 1'b0, 1'b0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
